// File: rtl/fp_addsub_sched.sv
// Round-robin front end that time-shares one external combinational FP add/sub unit.
// An issue register drives the unit, and a result register returns z with the requester id and tag.
module fp_addsub_sched #(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_op,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic [31:0]          fu_a,
  output logic [31:0]          fu_b,
  output logic                 fu_op,
  input  logic [31:0]          fu_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_z,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 busy,
  output logic [CNTW-1:0]      issued_cnt
);

  logic [31:0]     a_arr   [NREQ];
  logic [31:0]     b_arr   [NREQ];
  logic [TAGW-1:0] tag_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]   = req_a[gi*32 +: 32];
      assign b_arr[gi]   = req_b[gi*32 +: 32];
      assign tag_arr[gi] = req_tag[gi*TAGW +: TAGW];
    end
  endgenerate

  logic            v1_reg, v2_reg;
  logic [31:0]     a1_reg, b1_reg, z2_reg;
  logic            op1_reg;
  logic [IDW-1:0]  id1_reg, id2_reg, rr_ptr_reg;
  logic [TAGW-1:0] tag1_reg, tag2_reg;
  logic [CNTW-1:0] cnt_reg;

  logic           adv1, adv2, grant_vld, accept;
  logic [IDW-1:0] grant_idx;

  assign adv2 = !v2_reg || rsp_ready;
  assign adv1 = !v1_reg || adv2;

  // Scan starts one past the last grant so every waiting requester is reached within NREQ accepts.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_id;
    cand      = 0;
    cand_id   = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = IDW'(cand);
      if (!grant_vld && req_valid[cand_id]) begin
        grant_vld = 1'b1;
        grant_idx = cand_id;
      end
    end
  end

  // Ready is forced low while reset is asserted so nothing appears to be accepted then.
  always_comb begin
    req_ready = '0;
    if (grant_vld && rst_n) req_ready[grant_idx] = adv1;
  end

  assign accept = grant_vld && adv1 && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      a1_reg     <= '0;
      b1_reg     <= '0;
      op1_reg    <= 1'b0;
      id1_reg    <= '0;
      tag1_reg   <= '0;
      v2_reg     <= 1'b0;
      z2_reg     <= '0;
      id2_reg    <= '0;
      tag2_reg   <= '0;
      rr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (accept) begin
        v1_reg     <= 1'b1;
        a1_reg     <= a_arr[grant_idx];
        b1_reg     <= b_arr[grant_idx];
        op1_reg    <= req_op[grant_idx];
        id1_reg    <= grant_idx;
        tag1_reg   <= tag_arr[grant_idx];
        rr_ptr_reg <= grant_idx;
        if (cnt_reg != {CNTW{1'b1}}) cnt_reg <= cnt_reg + CNTW'(1);
      end else if (v1_reg && adv2) begin
        v1_reg <= 1'b0;
      end

      if (v1_reg && adv2) begin
        v2_reg   <= 1'b1;
        z2_reg   <= fu_z;
        id2_reg  <= id1_reg;
        tag2_reg <= tag1_reg;
      end else if (rsp_ready) begin
        v2_reg <= 1'b0;
      end
    end
  end

  assign fu_a       = a1_reg;
  assign fu_b       = b1_reg;
  assign fu_op      = op1_reg;
  assign rsp_valid  = v2_reg;
  assign rsp_z      = z2_reg;
  assign rsp_id     = id2_reg;
  assign rsp_tag    = tag2_reg;
  assign busy       = v1_reg || v2_reg;
  assign issued_cnt = cnt_reg;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched: a 4-requester/16-bit-counter build and a
// 2-requester/4-bit-counter build, each with a behavioural stand-in for the shared FP unit.
module tb_fp_addsub_sched;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Exact for the IEEE vectors used here; otherwise an operand-unique pattern so routing is visible.
  function automatic logic [31:0] fu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (!op && a == 32'h40000000 && b == 32'h3F800000) return 32'h40400000;
    if (op && a == b) return 32'h00000000;
    return a ^ {b[15:0], b[31:16]} ^ {31'b0, op};
  endfunction

  // Build A: NREQ=4, CNTW=16
  logic         rst_a;
  logic [3:0]   a_valid, a_ready, a_op;
  logic [127:0] a_a, a_b;
  logic [15:0]  a_tag;
  logic [31:0]  a_fu_a, a_fu_b, a_fu_z, a_rsp_z;
  logic         a_fu_op, a_rsp_valid, a_rsp_ready, a_busy;
  logic [1:0]   a_rsp_id;
  logic [3:0]   a_rsp_tag;
  logic [15:0]  a_cnt;

  assign a_fu_z = fu_model(a_fu_a, a_fu_b, a_fu_op);

  fp_addsub_sched #(.NREQ(4), .TAGW(4), .IDW(2), .CNTW(16)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .req_valid(a_valid), .req_ready(a_ready), .req_a(a_a), .req_b(a_b),
    .req_op(a_op), .req_tag(a_tag),
    .fu_a(a_fu_a), .fu_b(a_fu_b), .fu_op(a_fu_op), .fu_z(a_fu_z),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_z(a_rsp_z),
    .rsp_id(a_rsp_id), .rsp_tag(a_rsp_tag), .busy(a_busy), .issued_cnt(a_cnt)
  );

  // Build B: NREQ=2, CNTW=4
  logic        rst_b;
  logic [1:0]  b_valid, b_ready, b_op;
  logic [63:0] b_a, b_b;
  logic [7:0]  b_tag;
  logic [31:0] b_fu_a, b_fu_b, b_fu_z, b_rsp_z;
  logic        b_fu_op, b_rsp_valid, b_rsp_ready, b_busy;
  logic [0:0]  b_rsp_id;
  logic [3:0]  b_rsp_tag;
  logic [3:0]  b_cnt;

  assign b_fu_z = fu_model(b_fu_a, b_fu_b, b_fu_op);

  fp_addsub_sched #(.NREQ(2), .TAGW(4), .IDW(1), .CNTW(4)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .req_valid(b_valid), .req_ready(b_ready), .req_a(b_a), .req_b(b_b),
    .req_op(b_op), .req_tag(b_tag),
    .fu_a(b_fu_a), .fu_b(b_fu_b), .fu_op(b_fu_op), .fu_z(b_fu_z),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_z(b_rsp_z),
    .rsp_id(b_rsp_id), .rsp_tag(b_rsp_tag), .busy(b_busy), .issued_cnt(b_cnt)
  );

  // Bench-side copy of the operands given to build A.
  logic [31:0] ta [4];
  logic [31:0] tb [4];
  logic        top[4];
  logic [3:0]  ttg[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [3:0] tg);
    ta[i] = a; tb[i] = b; top[i] = op; ttg[i] = tg;
    a_a[i*32 +: 32] = a;
    a_b[i*32 +: 32] = b;
    a_op[i]         = op;
    a_tag[i*4 +: 4] = tg;
  endtask

  initial begin
    int g, prev_g, acc;
    logic [31:0] exp_cnt;

    rst_a = 1'b0; rst_b = 1'b0;
    a_valid = 4'b1111; a_a = '0; a_b = '0; a_op = '0; a_tag = '0; a_rsp_ready = 1'b1;
    b_valid = 2'b11;   b_a = '0; b_b = '0; b_op = '0; b_tag = '0; b_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_a(i, 32'h0, 32'h0, 1'b0, 4'h0);

    // Reset state, with requests pending so ready gating is exercised
    tick(); tick();
    chk("rst_ready_a", 32'(a_ready), 32'h0);
    chk("rst_rsp_valid_a", 32'(a_rsp_valid), 32'h0);
    chk("rst_busy_a", 32'(a_busy), 32'h0);
    chk("rst_cnt_a", 32'(a_cnt), 32'h0);
    chk("rst_fu_a", a_fu_a, 32'h0);
    chk("rst_rsp_z", a_rsp_z, 32'h0);
    chk("rst_ready_b", 32'(b_ready), 32'h0);
    chk("rst_cnt_b", 32'(b_cnt), 32'h0);
    a_valid = 4'b0000; b_valid = 2'b00;
    rst_a = 1'b1;
    tick();

    // 1: single add 2.0 + 1.0
    set_a(0, 32'h40000000, 32'h3F800000, 1'b0, 4'h5);
    a_valid = 4'b0001;
    #1 chk("t1_ready", 32'(a_ready), 32'h1);
    tick();
    a_valid = 4'b0000;
    chk("t1_fu_a", a_fu_a, 32'h40000000);
    chk("t1_fu_b", a_fu_b, 32'h3F800000);
    chk("t1_fu_op", 32'(a_fu_op), 32'h0);
    chk("t1_busy", 32'(a_busy), 32'h1);
    chk("t1_rsp_early", 32'(a_rsp_valid), 32'h0);
    chk("t1_cnt", 32'(a_cnt), 32'h1);
    tick();
    $display("t1 rsp z=%08h id=%0d tag=%0h", a_rsp_z, a_rsp_id, a_rsp_tag);
    chk("t1_rsp_valid", 32'(a_rsp_valid), 32'h1);
    chk("t1_rsp_z", a_rsp_z, 32'h40400000);
    chk("t1_rsp_id", 32'(a_rsp_id), 32'h0);
    chk("t1_rsp_tag", 32'(a_rsp_tag), 32'h5);
    tick();
    chk("t1_drain_valid", 32'(a_rsp_valid), 32'h0);
    chk("t1_drain_busy", 32'(a_busy), 32'h0);

    // 2: all four valid, grant order 1,2,3,0,1 at one accept per cycle
    for (int i = 0; i < 4; i++)
      set_a(i, 32'h10000000 + 32'(i), 32'h00000111 * 32'(i + 1), i[0], 4'(i + 8));
    a_valid = 4'b1111;
    prev_g = 0;
    for (int k = 0; k < 5; k++) begin
      g = (k + 1) % 4;
      #1 chk("t2_ready", 32'(a_ready), 32'(1 << g));
      tick();
      chk("t2_fu_a", a_fu_a, ta[g]);
      chk("t2_fu_op", 32'(a_fu_op), 32'(top[g]));
      if (k > 0) begin
        $display("t2 rsp id=%0d z=%08h", a_rsp_id, a_rsp_z);
        chk("t2_rsp_valid", 32'(a_rsp_valid), 32'h1);
        chk("t2_rsp_id", 32'(a_rsp_id), 32'(prev_g));
        chk("t2_rsp_z", a_rsp_z, fu_model(ta[prev_g], tb[prev_g], top[prev_g]));
        chk("t2_rsp_tag", 32'(a_rsp_tag), 32'(ttg[prev_g]));
      end
      prev_g = g;
    end
    a_valid = 4'b0000;
    tick();
    chk("t2_last_id", 32'(a_rsp_id), 32'(prev_g));
    chk("t2_last_z", a_rsp_z, fu_model(ta[prev_g], tb[prev_g], top[prev_g]));
    tick();
    chk("t2_idle", 32'(a_busy), 32'h0);
    chk("t2_cnt", 32'(a_cnt), 32'd6);

    // 3: 1.0 - 1.0 from requester 2 under backpressure, with 0 and 3 also valid
    set_a(2, 32'h3F800000, 32'h3F800000, 1'b1, 4'hA);
    a_rsp_ready = 1'b0;
    a_valid = 4'b1101;
    #1 chk("t3_ready_r2", 32'(a_ready), 32'h4);
    tick();
    a_valid = 4'b1001;
    #1 chk("t3_ready_r3", 32'(a_ready), 32'h8);
    tick();
    a_valid = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) tick();
      #1;
      chk("t3_stall_ready", 32'(a_ready), 32'h0);
      chk("t3_stall_valid", 32'(a_rsp_valid), 32'h1);
      chk("t3_stall_z", a_rsp_z, 32'h00000000);
      chk("t3_stall_id", 32'(a_rsp_id), 32'h2);
      chk("t3_stall_fu_a", a_fu_a, ta[3]);
      chk("t3_stall_cnt", 32'(a_cnt), 32'd8);
    end
    a_rsp_ready = 1'b1;
    #1 chk("t3_release_ready", 32'(a_ready), 32'h1);
    @(posedge clk); #1;
    a_valid = 4'b0000;
    $display("t3 rsp id=%0d z=%08h", a_rsp_id, a_rsp_z);
    chk("t3_drain_id3", 32'(a_rsp_id), 32'h3);
    chk("t3_drain_z3", a_rsp_z, fu_model(ta[3], tb[3], top[3]));
    tick();
    chk("t3_drain_id0", 32'(a_rsp_id), 32'h0);
    chk("t3_drain_z0", a_rsp_z, fu_model(ta[0], tb[0], top[0]));
    tick();
    chk("t3_empty", 32'(a_rsp_valid), 32'h0);
    chk("t3_cnt", 32'(a_cnt), 32'd9);

    // 4: asynchronous reset with both stages full
    a_rsp_ready = 1'b0;
    a_valid = 4'b0001;
    tick(); tick();
    chk("t4_pre_busy", 32'(a_busy), 32'h1);
    chk("t4_pre_valid", 32'(a_rsp_valid), 32'h1);
    chk("t4_pre_cnt", 32'(a_cnt), 32'd11);
    rst_a = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(a_rsp_valid), 32'h0);
    chk("t4_rst_busy", 32'(a_busy), 32'h0);
    chk("t4_rst_cnt", 32'(a_cnt), 32'h0);
    chk("t4_rst_ready", 32'(a_ready), 32'h0);
    a_valid = 4'b0000;
    tick();
    rst_a = 1'b1;
    a_rsp_ready = 1'b1;
    tick(); tick();
    chk("t4_post_valid", 32'(a_rsp_valid), 32'h0);
    chk("t4_post_busy", 32'(a_busy), 32'h0);

    // 5/6: NREQ=2, CNTW=4; requester 0 withdraws, requester 1 streams 20 accepts
    b_a = {32'h30000001, 32'h20000000};
    b_b = {32'h00000100, 32'h00000200};
    b_op = 2'b00;
    b_tag = {4'h3, 4'h7};
    rst_b = 1'b1;
    b_valid = 2'b11;
    #1 chk("t6_ready_first", 32'(b_ready), 32'h2);
    tick();
    acc = 1;
    b_valid = 2'b10;
    for (int j = 1; j < 20; j++) begin
      #1 chk("t6_ready", 32'(b_ready), 32'h2);
      tick();
      acc++;
      exp_cnt = (acc > 15) ? 32'hF : 32'(acc);
      chk("t5_cnt", 32'(b_cnt), exp_cnt);
      chk("t6_rsp_id", 32'(b_rsp_id), 32'h1);
      chk("t6_rsp_z", b_rsp_z, fu_model(32'h30000001, 32'h00000100, 1'b0));
    end
    b_valid = 2'b00;
    chk("t5_sat", 32'(b_cnt), 32'hF);
    tick(); tick();
    chk("t5_hold", 32'(b_cnt), 32'hF);
    chk("t6_idle", 32'(b_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
